// File: rtl/mor1kx_execute_serial_div.sv
// mor1kx_execute_serial_div: radix-2 restoring serial divider for l.div/l.divu, one quotient bit per clock.
// Optional MOR1KX_DIV_REMAINDER_EN adds remainder_o (sign follows dividend).
module mor1kx_execute_serial_div #(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pipeline_flush_i,
    input  logic                            start_i,
    input  logic                            signed_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rfa_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rfb_i,
    input  logic                            ack_i,
    output logic                            busy_o,
    output logic                            valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
`ifdef MOR1KX_DIV_REMAINDER_EN
    output logic [OPTION_OPERAND_WIDTH-1:0] remainder_o,
`endif
    output logic                            overflow_o
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_div;
    logic           r_qneg;
    logic           r_dz;
    logic           r_ovf;
    logic           r_valid;
    logic [W-1:0]   r_result;
    logic           r_overflow;

    logic           w_accept;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W:0]     w_sh;
    logic [W-1:0]   w_trial;
    logic           w_ge;
    logic [W-1:0]   w_rem_next;
    logic [W-1:0]   w_quo_next;
    logic           w_last;
    logic           w_finish;

    assign w_accept   = !pipeline_flush_i & start_i & ((r_state == IDLE) | ((r_state == DONE) & ack_i));
    assign w_a_neg    = signed_i & rfa_i[W-1];
    assign w_b_neg    = signed_i & rfb_i[W-1];
    // Partial remainder never exceeds the divisor, so the W-bit difference is exact whenever it is kept.
    assign w_sh       = {r_rem, r_quo[W-1]};
    assign w_trial    = w_sh[W-1:0] - r_div;
    assign w_ge       = w_sh >= {1'b0, r_div};
    assign w_rem_next = w_ge ? w_trial : w_sh[W-1:0];
    assign w_quo_next = {r_quo[W-2:0], w_ge};
    assign w_last     = r_cnt == CW'(W - 1);
    assign w_finish   = !pipeline_flush_i & (r_state == CALC) & (r_dz | w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_qneg     <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (pipeline_flush_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= CALC;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_neg ? -rfa_i : rfa_i;
            r_div   <= w_b_neg ? -rfb_i : rfb_i;
            r_qneg  <= w_a_neg ^ w_b_neg;
            r_dz    <= rfb_i == '0;
            r_ovf   <= signed_i & (rfa_i == {1'b1, {(W-1){1'b0}}}) & (&rfb_i);
        end else if (r_state == CALC) begin
            if (r_dz) begin
                r_state    <= DONE;
                r_valid    <= 1'b1;
                r_result   <= '0;
                r_overflow <= 1'b1;
            end else begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_state    <= DONE;
                    r_valid    <= 1'b1;
                    r_result   <= r_qneg ? -w_quo_next : w_quo_next;
                    r_overflow <= r_ovf;
                end
            end
        end else if ((r_state == DONE) & ack_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
    end

`ifdef MOR1KX_DIV_REMAINDER_EN
    logic           r_dneg;
    logic [W-1:0]   r_remainder;
    logic [W-1:0]   w_rem_src;

    // On divide-by-zero r_quo still holds |rfa|, so re-applying the dividend sign recovers rfa as sampled.
    assign w_rem_src = r_dz ? r_quo : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dneg      <= 1'b0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_dneg <= w_a_neg;
        end else if (w_finish) begin
            r_remainder <= r_dneg ? -w_rem_src : w_rem_src;
        end
    end

    assign remainder_o = r_remainder;
`endif

    assign busy_o     = (r_state == CALC) | ((r_state == DONE) & !ack_i);
    assign valid_o    = r_valid;
    assign result_o   = r_result;
    assign overflow_o = r_overflow;
endmodule

// File: tb/tb_mor1kx_execute_serial_div.sv
// tb_mor1kx_execute_serial_div: directed and random checks of the serial divider against an arithmetic model.
module tb_mor1kx_execute_serial_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rfa = '0;
    logic [31:0] rfb = '0;
    logic        busy;
    logic        valid;
    logic        ovf;
    logic [31:0] res;
`ifdef MOR1KX_DIV_REMAINDER_EN
    logic [31:0] rem;
`endif
    int          vectors = 0;
    int          miscompares = 0;

    mor1kx_execute_serial_div #(.OPTION_OPERAND_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush_i (flush),
        .start_i          (start),
        .signed_i         (sgn),
        .rfa_i            (rfa),
        .rfb_i            (rfb),
        .ack_i            (ack),
        .busy_o           (busy),
        .valid_o          (valid),
        .result_o         (res),
`ifdef MOR1KX_DIV_REMAINDER_EN
        .remainder_o      (rem),
`endif
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes the dividend sign.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic o, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) begin
            q = 0; o = 1'b1; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; o = 1'b1; r = 0;
        end else if (s) begin
            q = 32'(sa / sb); o = 1'b0; r = 32'(sa % sb);
        end else begin
            q = a / b; o = 1'b0; r = a % b;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic with_ack);
        logic [31:0] eq;
        logic [31:0] er;
        logic        eo;
        int          lat;
        logic        busy_ok;
        model(a, b, s, eq, eo, er);
        rfa = a; rfb = b; sgn = s; start = 1'b1; ack = with_ack;
        tick;
        start = 1'b0; ack = 1'b0;
        chk("valid_after_start", {31'b0, valid}, 32'd0);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (!busy) busy_ok = 1'b0;
            tick;
            if (valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), (b == 0) ? 32'd1 : 32'd32);
        chk("busy_during_calc", {31'b0, busy_ok}, 32'd1);
        chk("result", res, eq);
        chk("overflow", {31'b0, ovf}, {31'b0, eo});
        chk("busy_in_done", {31'b0, busy}, 32'd1);
`ifdef MOR1KX_DIV_REMAINDER_EN
        chk("remainder", rem, er);
`endif
    endtask

    task automatic ack_done;
        ack = 1'b1;
        #1;
        chk("busy_on_ack", {31'b0, busy}, 32'd0);
        tick;
        ack = 1'b0;
        chk("valid_after_ack", {31'b0, valid}, 32'd0);
        chk("busy_after_ack", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        logic        ok;
        int          m;
        tick;
        tick;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_overflow", {31'b0, ovf}, 32'd0);
        rst = 1'b0;
        tick;

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        chk("udiv_100_7", res, 32'd14);
        ack_done;
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
        chk("sdiv_m100_7", res, 32'hFFFF_FFF2);
        ack_done;
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
        chk("sdiv_100_m7", res, 32'hFFFF_FFF2);
        ack_done;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("sdiv_ovf_flag", {31'b0, ovf}, 32'd1);
        ack_done;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        ack_done;
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0);
        chk("div0_flag", {31'b0, ovf}, 32'd1);
        ack_done;

        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        held = res;
        ok = 1'b1;
        rfa = 32'd5; rfb = 32'd1; sgn = 1'b0; start = 1'b1;
        repeat (5) begin
            tick;
            if (res !== held || valid !== 1'b1 || busy !== 1'b1) ok = 1'b0;
        end
        start = 1'b0;
        chk("hold_stable", {31'b0, ok}, 32'd1);
        chk("hold_value", res, 32'hFFFF_FFFF);
        run_op(32'd20, 32'd3, 1'b0, 1'b1);
        chk("back_to_back", res, 32'd6);
        ack_done;

        rfa = 32'd1000; rfb = 32'd3; sgn = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_valid", {31'b0, valid}, 32'd0);
        ok = 1'b1;
        repeat (40) begin
            tick;
            if (valid || busy) ok = 1'b0;
        end
        chk("flush_quiet", {31'b0, ok}, 32'd1);
        run_op(32'd1000, 32'd3, 1'b0, 1'b0);
        ack_done;

        repeat (30) begin
            m = int'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            if (m == 0) b = 32'd0;
            else if (m <= 3) b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
            else if (m == 4) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(a, b, 1'($urandom_range(0, 1)), 1'b0);
            ack_done;
        end

        run_op(32'd99, 32'd4, 1'b0, 1'b0);
        ack_done;
        rfa = 32'd77; rfb = 32'd5; sgn = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (14) tick;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_valid", {31'b0, valid}, 32'd0);
        chk("arst_result", res, 32'd0);
        chk("arst_overflow", {31'b0, ovf}, 32'd0);
`ifdef MOR1KX_DIV_REMAINDER_EN
        chk("arst_remainder", rem, 32'd0);
`endif
        tick;
        rst = 1'b0;
        tick;
        run_op(32'd45, 32'd6, 1'b0, 1'b0);
        ack_done;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mor1kx_execute_serial_div.md
Name: mor1kx_execute_serial_div

Overview:
- Multicycle serial integer divider in the cappuccino execute stage, implementing l.div and l.divu.
- Consumes the bypassed operands the register file presents to execute (execute_rfa/execute_rfb) and returns a quotient plus overflow flag to the ctrl stage.
- Holds the pipeline via busy until the result is consumed on the ctrl advance.
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- OPTION_OPERAND_WIDTH, 32, operand/result width; must be even and ≥ 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pipeline_flush_i  in  1  abort any operation
- start_i  in  1  one-cycle request; operands valid this cycle
- signed_i  in  1  1 = l.div (two's complement), 0 = l.divu; sampled with start_i
- rfa_i  in  WIDTH  dividend
- rfb_i  in  WIDTH  divisor
- ack_i  in  1  ctrl stage consumed result (padv_ctrl)
- busy_o  out  1  operation in progress or result not yet consumed
- valid_o  out  1  result_o/overflow_o valid
- result_o  out  WIDTH  quotient
- overflow_o  out  1  divide-by-zero or signed overflow

Behaviour:
- Reset: state IDLE, busy_o=0, valid_o=0, result_o=0, overflow_o=0, counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 & !pipeline_flush_i → CALC.
  - Latch |rfa| and |rfb|; take absolute value only when signed_i=1.
  - Latch quotient sign = signed_i & (rfa msb ^ rfb msb).
  - Latch dividend sign; clear partial remainder; counter=0.
- CALC, each edge:
  - {rem,quo} shifted left 1.
  - trial = rem − divisor (WIDTH+1 bits).
  - If trial ≥ 0: rem=trial, quo lsb=1; else quo lsb=0.
  - counter++.
  - When counter reaches WIDTH−1, that edge performs the last iteration, registers the sign-corrected quotient (negated if quotient sign set), and goes to DONE.
- Latency: valid_o rises exactly WIDTH cycles after the edge that sampled start_i (32 for default).
- Divide-by-zero (rfb_i==0 at start):
  - IDLE → CALC, then DONE on the next edge (latency 1).
  - result_o=0, overflow_o=1.
- Signed overflow (signed_i, rfa=0x80..0, rfb=all-ones):
  - Full latency; result_o=0x80..0, overflow_o=1.
- Otherwise overflow_o=0. Unsigned results never set overflow.
- DONE:
  - valid_o=1; result_o/overflow_o held stable.
  - ack_i=1 → IDLE next edge.
  - ack_i=1 & start_i=1 in the same cycle → accept new operation directly (→ CALC); valid_o drops.
- busy_o = (state==CALC) | (state==DONE & !ack_i). It is combinational, for pipeline stall logic.
- start_i in CALC, or in DONE without ack_i: ignored; no effect on the in-flight result.
- pipeline_flush_i in any state: → IDLE next edge; valid_o=0 and busy_o=0 from then on. Flush dominates start_i and ack_i in the same cycle.
- result_o retains its last value in IDLE; consumers must qualify it with valid_o.
- rst asserted mid-operation: immediate return to reset values, no clock required.

Optional Feature:
- Macro: MOR1KX_DIV_REMAINDER_EN.
- Defined:
  - Adds output port remainder_o (WIDTH).
  - Value: final partial remainder, negated when the signed dividend was negative (sign follows dividend).
  - Registered and valid with valid_o.
  - Divide-by-zero: remainder_o = rfa_i as sampled.
  - Signed overflow: remainder_o = 0.
- Undefined: port and remainder sign-fixup logic absent; quotient behaviour identical.

Test Plan:
- Unsigned 100/7, start at cycle 0 → valid_o at cycle 32, result_o=14, overflow_o=0, busy_o high cycles 1–32; remainder_o=2 with macro.
- Signed 0xFFFFFF9C/7 (−100/7) → result_o=0xFFFFFFF2, overflow_o=0; remainder_o=0xFFFFFFFE with macro. Signed 100/0xFFFFFFF9 → 0xFFFFFFF2, remainder 2.
- Signed 0x80000000/0xFFFFFFFF → result_o=0x80000000, overflow_o=1 at cycle 32. Unsigned same operands → result_o=0, overflow_o=0.
- Divisor 0, dividend 0x1234 → valid_o one cycle after start, result_o=0, overflow_o=1; remainder_o=0x1234 with macro.
- Unsigned 0xFFFFFFFF/1 → 0xFFFFFFFF. Hold ack_i low 5 cycles: result stable, extra start_i ignored. ack_i+start_i together (20/3) → next result 6, no idle gap.
- Flush at cycle 10 of an operation → valid_o never asserts, busy_o low from cycle 11, new start computes correctly. Assert rst at cycle 15 of an operation → all outputs 0 asynchronously.
